rapid_mmio_bridge: RTL and testbench

- Sits directly downstream of the CPU data-memory port; consumes mmu_address / mmu_output_data / mmu_we and returns mmu_input_data.
- Decodes each access to one of two targets:
  - external synchronous data RAM (pass-through);
  - internal MMIO bank: GPIO, 64-bit machine timer with compare interrupt, optional UART TX.
- Gives the core memory-mapped I/O without touching the pipeline.

---
 rtl/rapid_mmio_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_rapid_mmio_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rapid_mmio_bridge.sv
// rapid_mmio_bridge: splits the CPU data port between synchronous data RAM and a small MMIO bank
// (GPIO, 64-bit machine timer with compare IRQ, optional UART TX built when RAPID_MMIO_UART_EN is defined).
module rapid_mmio_bridge #(
  parameter int GPIO_W         = 32,
  parameter int TIMER_PRESCALE = 1,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_mmu_address,
  input  logic [31:0]       i_mmu_wdata,
  input  logic [3:0]        i_mmu_we,
  output logic [31:0]       o_mmu_rdata,
  output logic [31:0]       o_ram_address,
  output logic [31:0]       o_ram_wdata,
  output logic [3:0]        o_ram_we,
  input  logic [31:0]       i_ram_rdata,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic              o_timer_irq,
  output logic              o_uart_tx
);

  localparam logic [5:0] OFF_GPIO_OUT = 6'd0;
  localparam logic [5:0] OFF_GPIO_IN  = 6'd1;
  localparam logic [5:0] OFF_MTIME_LO = 6'd2;
  localparam logic [5:0] OFF_MTIME_HI = 6'd3;
  localparam logic [5:0] OFF_CMP_LO   = 6'd4;
  localparam logic [5:0] OFF_CMP_HI   = 6'd5;
  localparam logic [5:0] OFF_CTRL     = 6'd6;
  localparam logic [5:0] OFF_UART     = 6'd7;
  localparam logic [31:0] PRESCALE_LAST = 32'(TIMER_PRESCALE - 1);

  function automatic logic [31:0] merge_be(input logic [31:0] old_val, input logic [31:0] new_val,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic              sel_mmio_s;
  logic [5:0]        off_s;
  logic              wr_s;
  logic              rd_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       gpio_out_ext_s;
  logic [31:0]       gpio_in_ext_s;
  logic [31:0]       gpio_merged_s;
  logic              tick_s;
  logic              cmp_hit_s;
  logic              w1c_s;
  logic              uart_busy_s;

  logic              sel_r;
  logic [31:0]       mmio_r;
  logic [GPIO_W-1:0] gpio_out_r;
  logic [GPIO_W-1:0] gpio_sync1_r;
  logic [GPIO_W-1:0] gpio_sync2_r;
  logic [63:0]       mtime_r;
  logic [63:0]       mtimecmp_r;
  logic [31:0]       shadow_r;
  logic [31:0]       presc_r;
  logic              en_r;
  logic              pend_r;
  logic              irq_r;

  assign sel_mmio_s    = i_mmu_address[31];
  assign off_s         = i_mmu_address[7:2];
  assign wr_s          = sel_mmio_s && (i_mmu_we != 4'd0);
  assign rd_s          = sel_mmio_s && (i_mmu_we == 4'd0);
  assign o_ram_address = i_mmu_address;
  assign o_ram_wdata   = i_mmu_wdata;
  assign o_ram_we      = sel_mmio_s ? 4'd0 : i_mmu_we;

  assign tick_s        = en_r && (presc_r == PRESCALE_LAST);
  assign cmp_hit_s     = en_r && (mtime_r >= mtimecmp_r);
  assign w1c_s         = wr_s && (off_s == OFF_CTRL) && i_mmu_we[0] && i_mmu_wdata[1];
  assign gpio_merged_s = merge_be(gpio_out_ext_s, i_mmu_wdata, i_mmu_we);

  // Zero-extend the GPIO registers to the 32-bit bus
  always_comb begin
    gpio_out_ext_s = 32'd0;
    gpio_in_ext_s  = 32'd0;
    gpio_out_ext_s[GPIO_W-1:0] = gpio_out_r;
    gpio_in_ext_s[GPIO_W-1:0]  = gpio_sync2_r;
  end

  // MMIO read mux for the currently addressed register
  always_comb begin
    rd_data_s = 32'd0;
    case (off_s)
      OFF_GPIO_OUT: rd_data_s = gpio_out_ext_s;
      OFF_GPIO_IN:  rd_data_s = gpio_in_ext_s;
      OFF_MTIME_LO: rd_data_s = mtime_r[31:0];
      OFF_MTIME_HI: rd_data_s = shadow_r;
      OFF_CMP_LO:   rd_data_s = mtimecmp_r[31:0];
      OFF_CMP_HI:   rd_data_s = mtimecmp_r[63:32];
      OFF_CTRL:     rd_data_s = {30'd0, pend_r, en_r};
      OFF_UART:     rd_data_s = {31'd0, uart_busy_s};
      default:      rd_data_s = 32'd0;
    endcase
  end

  // Register bank, timer and interrupt state
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sel_r        <= 1'b1;  // selects the cleared mmio_r so the load bus reads 0 out of reset
      mmio_r       <= 32'd0;
      gpio_out_r   <= '0;
      gpio_sync1_r <= '0;
      gpio_sync2_r <= '0;
      mtime_r      <= 64'd0;
      mtimecmp_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_r     <= 32'd0;
      presc_r      <= 32'd0;
      en_r         <= 1'b0;
      pend_r       <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      sel_r        <= sel_mmio_s;
      mmio_r       <= sel_mmio_s ? rd_data_s : 32'd0;
      gpio_sync1_r <= i_gpio_in;
      gpio_sync2_r <= gpio_sync1_r;
      if (wr_s && (off_s == OFF_GPIO_OUT)) gpio_out_r <= gpio_merged_s[GPIO_W-1:0];
      if (rd_s && (off_s == OFF_MTIME_LO)) shadow_r <= mtime_r[63:32];
      if (en_r) presc_r <= tick_s ? 32'd0 : presc_r + 32'd1;
      // A CPU write to either mtime half drops the increment of that cycle
      if (wr_s && (off_s == OFF_MTIME_LO)) begin
        mtime_r[31:0] <= merge_be(mtime_r[31:0], i_mmu_wdata, i_mmu_we);
      end else if (wr_s && (off_s == OFF_MTIME_HI)) begin
        mtime_r[63:32] <= merge_be(mtime_r[63:32], i_mmu_wdata, i_mmu_we);
      end else if (tick_s) begin
        mtime_r <= mtime_r + 64'd1;
      end
      if (wr_s && (off_s == OFF_CMP_LO)) mtimecmp_r[31:0] <= merge_be(mtimecmp_r[31:0], i_mmu_wdata, i_mmu_we);
      if (wr_s && (off_s == OFF_CMP_HI)) mtimecmp_r[63:32] <= merge_be(mtimecmp_r[63:32], i_mmu_wdata, i_mmu_we);
      if (wr_s && (off_s == OFF_CTRL) && i_mmu_we[0]) en_r <= i_mmu_wdata[0];
      if (cmp_hit_s) begin
        pend_r <= 1'b1;
      end else if (w1c_s) begin
        pend_r <= 1'b0;
      end
      irq_r <= pend_r & en_r;
    end
  end

  assign o_mmu_rdata = sel_r ? mmio_r : i_ram_rdata;
  assign o_gpio_out  = gpio_out_r;
  assign o_timer_irq = irq_r;

`ifdef RAPID_MMIO_UART_EN
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
  localparam logic [31:0] BIT_LAST = 32'(CLKS_PER_BIT - 1);

  uart_state_t uart_state_r;
  logic [31:0] uart_cnt_r;
  logic [2:0]  uart_bit_r;
  logic [7:0]  uart_shift_r;
  logic        uart_tx_r;
  logic        uart_load_s;
  logic        uart_bit_end_s;

  assign uart_busy_s    = (uart_state_r != UART_IDLE);
  assign uart_load_s    = wr_s && (off_s == OFF_UART) && i_mmu_we[0] && !uart_busy_s;
  assign uart_bit_end_s = (uart_cnt_r == BIT_LAST);

  // UART transmit FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      uart_state_r <= UART_IDLE;
      uart_cnt_r   <= 32'd0;
      uart_bit_r   <= 3'd0;
      uart_shift_r <= 8'd0;
      uart_tx_r    <= 1'b1;
    end else begin
      case (uart_state_r)
        UART_IDLE: begin
          uart_cnt_r <= 32'd0;
          if (uart_load_s) begin
            uart_state_r <= UART_START;
            uart_shift_r <= i_mmu_wdata[7:0];
            uart_tx_r    <= 1'b0;
          end
        end
        UART_START: begin
          uart_cnt_r <= uart_bit_end_s ? 32'd0 : uart_cnt_r + 32'd1;
          if (uart_bit_end_s) begin
            uart_state_r <= UART_DATA;
            uart_bit_r   <= 3'd0;
            uart_tx_r    <= uart_shift_r[0];
          end
        end
        UART_DATA: begin
          uart_cnt_r <= uart_bit_end_s ? 32'd0 : uart_cnt_r + 32'd1;
          if (uart_bit_end_s) begin
            if (uart_bit_r == 3'd7) begin
              uart_state_r <= UART_STOP;
              uart_tx_r    <= 1'b1;
            end else begin
              uart_bit_r   <= uart_bit_r + 3'd1;
              uart_shift_r <= {1'b0, uart_shift_r[7:1]};
              uart_tx_r    <= uart_shift_r[1];
            end
          end
        end
        UART_STOP: begin
          uart_cnt_r <= uart_bit_end_s ? 32'd0 : uart_cnt_r + 32'd1;
          if (uart_bit_end_s) uart_state_r <= UART_IDLE;
        end
        default: begin
          uart_state_r <= UART_IDLE;
          uart_tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign o_uart_tx = uart_tx_r;
`else
  assign uart_busy_s = 1'b0;
  assign o_uart_tx   = 1'b1;
`endif

endmodule

// File: tb/tb_rapid_mmio_bridge.sv
// Self-checking bench for rapid_mmio_bridge: directed scenarios plus randomized bus traffic
// compared every cycle against a register-level reference model.
module tb_rapid_mmio_bridge;
  localparam int GPIO_W         = 16;
  localparam int TIMER_PRESCALE = 1;
  localparam int CLKS_PER_BIT   = 4;
  localparam logic [31:0] GPIO_MASK = 32'h0000_FFFF;
  localparam logic [31:0] MMIO = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       mmu_address, mmu_wdata, mmu_rdata;
  logic [3:0]        mmu_we;
  logic [31:0]       ram_address, ram_wdata, ram_rdata;
  logic [3:0]        ram_we;
  logic [GPIO_W-1:0] gpio_in, gpio_out;
  logic              timer_irq, uart_tx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rapid_mmio_bridge #(.GPIO_W(GPIO_W), .TIMER_PRESCALE(TIMER_PRESCALE), .CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_mmu_address(mmu_address), .i_mmu_wdata(mmu_wdata), .i_mmu_we(mmu_we), .o_mmu_rdata(mmu_rdata),
    .o_ram_address(ram_address), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we), .i_ram_rdata(ram_rdata),
    .i_gpio_in(gpio_in), .o_gpio_out(gpio_out), .o_timer_irq(timer_irq), .o_uart_tx(uart_tx)
  );

  // Synchronous data RAM seen by the bridge (read returns pre-write contents)
  logic [31:0] env_ram [0:255];
  always @(posedge clk) begin
    ram_rdata <= env_ram[ram_address[9:2]];
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) env_ram[ram_address[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Reference model state
  logic [31:0] r_mem [0:255];
  logic [63:0] r_mtime, r_cmp;
  logic [31:0] r_shadow, r_gpio_out, r_sync1, r_sync2, r_rdata;
  int          r_presc;
  logic        r_en, r_pend, r_irq, r_busy, r_tx;
  bit          r_txq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    r_mtime = 64'd0; r_cmp = 64'hFFFF_FFFF_FFFF_FFFF; r_shadow = 32'd0; r_gpio_out = 32'd0;
    r_sync1 = 32'd0; r_sync2 = 32'd0; r_rdata = 32'd0; r_presc = 0;
    r_en = 1'b0; r_pend = 1'b0; r_irq = 1'b0; r_busy = 1'b0; r_tx = 1'b1;
    r_txq.delete();
  endtask

  // One clock edge of the register-level behaviour
  task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            input logic rn, input logic [GPIO_W-1:0] gi);
    logic sel, wr, tick, hit, clr;
    logic [5:0] off;
    logic [31:0] rd;
    logic [63:0] nt;
    if (!rn) begin
      model_reset();
      return;
    end
    sel = a[31]; off = a[7:2]; wr = (be != 4'd0); clr = 1'b0;
    rd = 32'd0;
    if (sel) begin
      case (off)
        6'd0: rd = r_gpio_out;
        6'd1: rd = r_sync2;
        6'd2: rd = r_mtime[31:0];
        6'd3: rd = r_shadow;
        6'd4: rd = r_cmp[31:0];
        6'd5: rd = r_cmp[63:32];
        6'd6: rd = {30'd0, r_pend, r_en};
        6'd7: rd = {31'd0, r_busy};
        default: rd = 32'd0;
      endcase
    end
    r_rdata = sel ? rd : r_mem[a[9:2]];
    if (!sel && wr) r_mem[a[9:2]] = be_merge(r_mem[a[9:2]], wd, be);
    tick = r_en && (r_presc == TIMER_PRESCALE - 1);
    hit  = r_en && (r_mtime >= r_cmp);
    r_irq = r_pend && r_en;
    r_sync2 = r_sync1;
    r_sync1 = 32'(gi);
    if (r_en) r_presc = tick ? 0 : r_presc + 1;
    nt = tick ? r_mtime + 64'd1 : r_mtime;
    if (sel && wr) begin
      case (off)
        6'd0: r_gpio_out = be_merge(r_gpio_out, wd, be) & GPIO_MASK;
        6'd2: nt = {r_mtime[63:32], be_merge(r_mtime[31:0], wd, be)};
        6'd3: nt = {be_merge(r_mtime[63:32], wd, be), r_mtime[31:0]};
        6'd4: r_cmp[31:0] = be_merge(r_cmp[31:0], wd, be);
        6'd5: r_cmp[63:32] = be_merge(r_cmp[63:32], wd, be);
        6'd6: if (be[0]) begin clr = wd[1]; r_en = wd[0]; end
`ifdef RAPID_MMIO_UART_EN
        6'd7: if (be[0] && !r_busy) begin
          for (int b = 0; b < 10; b++) begin
            bit v;
            v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : wd[b-1];
            repeat (CLKS_PER_BIT) r_txq.push_back(v);
          end
        end
`endif
        default: ;
      endcase
    end
    if (sel && !wr && off == 6'd2) r_shadow = r_mtime[63:32];
    r_mtime = nt;
    r_pend = hit ? 1'b1 : (clr ? 1'b0 : r_pend);
    if (r_txq.size() > 0) begin
      r_tx = r_txq.pop_front();
      r_busy = 1'b1;
    end else begin
      r_tx = 1'b1;
      r_busy = 1'b0;
    end
  endtask

  // One bus cycle: drive, check combinational RAM side, clock, check registered outputs
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    mmu_address = a; mmu_wdata = wd; mmu_we = be;
    gpio_in = GPIO_W'($urandom);
    #1;
    check_eq("ram_we", ram_we, a[31] ? 4'h0 : be);
    check_eq("ram_addr", ram_address, a);
    @(posedge clk);
    model_step(a, wd, be, reset_n, gpio_in);
    #1;
    check_eq("rdata", mmu_rdata, r_rdata);
    check_eq("gpio_out", gpio_out, r_gpio_out[GPIO_W-1:0]);
    check_eq("irq", timer_irq, r_irq);
    check_eq("uart_tx", uart_tx, r_tx);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin env_ram[i] = 32'd0; r_mem[i] = 32'd0; end
    model_reset();
    reset_n = 1'b0;
    repeat (3) bus(32'd0, 32'd0, 4'd0);
    check_eq("reset_rdata", mmu_rdata, 32'd0);
    check_eq("reset_uart_tx", uart_tx, 1'b1);
    reset_n = 1'b1;

    // RAM pass-through
    bus(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    bus(32'h0000_0100, 32'd0, 4'h0);
    check_eq("ram_readback", mmu_rdata, 32'hDEAD_BEEF);

    // GPIO byte-lane write and aliased readback
    bus(MMIO, 32'h1234_5678, 4'b0010);
    check_eq("gpio_lane1", gpio_out, 16'h5600);
    bus(32'h8123_4503, 32'd0, 4'h0);
    check_eq("gpio_alias_rd", mmu_rdata, 32'h0000_5600);

    // mtime carry into the upper half and shadowed HI read
    bus(MMIO + 32'h08, 32'hFFFF_FFFE, 4'hF);
    bus(MMIO + 32'h0C, 32'd0, 4'hF);
    bus(MMIO + 32'h18, 32'd1, 4'h1);
    repeat (3) bus(32'd0, 32'd0, 4'd0);
    bus(MMIO + 32'h08, 32'd0, 4'h0);
    check_eq("mtime_lo", mmu_rdata, 32'd1);
    bus(MMIO + 32'h0C, 32'd0, 4'h0);
    check_eq("mtime_hi_shadow", mmu_rdata, 32'd1);

    // Compare interrupt, set-wins W1C, then clear once below compare
    bus(MMIO + 32'h18, 32'd2, 4'h1);
    bus(MMIO + 32'h08, 32'd0, 4'hF);
    bus(MMIO + 32'h0C, 32'd0, 4'hF);
    bus(MMIO + 32'h14, 32'd0, 4'hF);
    bus(MMIO + 32'h10, 32'd10, 4'hF);
    bus(MMIO + 32'h18, 32'd1, 4'h1);
    n = 0;
    while (timer_irq !== 1'b1 && n < 20) begin
      bus(32'd0, 32'd0, 4'd0);
      n++;
    end
    check_eq("irq_within_12", (n <= 12), 1'b1);
    bus(MMIO + 32'h18, 32'd3, 4'h1);
    bus(32'd0, 32'd0, 4'd0);
    check_eq("irq_set_wins", timer_irq, 1'b1);
    bus(MMIO + 32'h14, 32'd1, 4'hF);
    bus(MMIO + 32'h18, 32'd3, 4'h1);
    bus(32'd0, 32'd0, 4'd0);
    check_eq("irq_cleared", timer_irq, 1'b0);

    // Reset mid-count
    bus(MMIO, 32'h0000_00A5, 4'h1);
    reset_n = 1'b0;
    bus(32'd0, 32'd0, 4'd0);
    reset_n = 1'b1;
    check_eq("rst_irq", timer_irq, 1'b0);
    check_eq("rst_gpio", gpio_out, 16'h0000);
    check_eq("rst_rdata", mmu_rdata, 32'd0);
    bus(MMIO + 32'h14, 32'd0, 4'h0);
    check_eq("rst_cmp_hi", mmu_rdata, 32'hFFFF_FFFF);
    bus(MMIO + 32'h18, 32'd0, 4'h0);
    check_eq("rst_ctrl", mmu_rdata, 32'd0);
    bus(MMIO + 32'h08, 32'd0, 4'h0);
    check_eq("rst_mtime", mmu_rdata, 32'd0);

`ifdef RAPID_MMIO_UART_EN
    begin
      int seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      bus(MMIO + 32'h1C, 32'h0000_00A5, 4'h1);
      check_eq("uart_bit0", uart_tx, 1'(seq[0]));
      for (int i = 1; i < 40; i++) begin
        if (i == 10) begin
          bus(MMIO + 32'h1C, 32'd0, 4'h0);
          check_eq("uart_busy", mmu_rdata, 32'd1);
        end else if (i == 20) begin
          bus(MMIO + 32'h1C, 32'h0000_00FF, 4'h1);
        end else begin
          bus(32'd0, 32'd0, 4'd0);
        end
        if (i % 4 == 0) check_eq($sformatf("uart_bit%0d", i / 4), uart_tx, 1'(seq[i / 4]));
      end
      repeat (2) bus(32'd0, 32'd0, 4'd0);
      bus(MMIO + 32'h1C, 32'd0, 4'h0);
      check_eq("uart_idle", mmu_rdata, 32'd0);
    end
`else
    bus(MMIO + 32'h1C, 32'h0000_00A5, 4'h1);
    bus(MMIO + 32'h1C, 32'd0, 4'h0);
    check_eq("uart_off_rd", mmu_rdata, 32'd0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [31:0] a;
      logic [5:0]  off;
      logic [3:0]  be;
      reset_n = ($urandom_range(0, 149) != 0);
      off = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) a = $urandom & 32'h0000_03FF;
      else a = {1'b1, 23'($urandom), off, 2'($urandom)};
      be = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus(a, $urandom, be);
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
